// File: rtl/max_unpooling_stream.sv
// max_unpooling_stream: channel-serial 2x2 max-unpooling.
// Buffers one pooled row (value + argmax position), then emits the two
// restored output rows in raster order, zero everywhere except the argmax slot.
module max_unpooling_stream #(
    parameter int DATA_BITS = 32,
    parameter int D         = 32,
    parameter int H         = 23,
    parameter int W         = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic [1:0]           in_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_last,
    output logic                 frame_done
);

    localparam int CIW = (W > 1) ? $clog2(W) : 1;
    localparam int COW = $clog2(2 * W);
    localparam int PRW = (H > 1) ? $clog2(H) : 1;
    localparam int CHW = (D > 1) ? $clog2(D) : 1;

    localparam logic [CIW-1:0] COL_IN_LAST  = CIW'(W - 1);
    localparam logic [COW-1:0] COL_OUT_LAST = COW'(2 * W - 1);
    localparam logic [PRW-1:0] PROW_LAST    = PRW'(H - 1);
    localparam logic [CHW-1:0] CHAN_LAST    = CHW'(D - 1);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        EMIT_TOP = 2'd1,
        EMIT_BOT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CIW-1:0] col_in_q, col_in_d;
    logic [COW-1:0] col_out_q, col_out_d;
    logic [PRW-1:0] prow_q, prow_d;
    logic [CHW-1:0] chan_q, chan_d;
    logic           frame_done_q, frame_done_d;

    logic [DATA_BITS-1:0] buf_val_q [W];
    logic [1:0]           buf_idx_q [W];
    logic                 buf_we;
    logic [CIW-1:0]       rd_addr;
    logic                 emit_bot;

    assign frame_done = frame_done_q;

    // Row buffer write; contents need no reset since every entry is
    // rewritten during FILL before the emit phases read it.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_val_q[col_in_q] <= in_data;
            buf_idx_q[col_in_q] <= in_idx;
        end
    end

    // State, counters and frame pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            col_in_q     <= '0;
            col_out_q    <= '0;
            prow_q       <= '0;
            chan_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_in_q     <= col_in_d;
            col_out_q    <= col_out_d;
            prow_q       <= prow_d;
            chan_q       <= chan_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state, counter updates and handshake/output decode.
    always_comb begin
        state_d      = state_q;
        col_in_d     = col_in_q;
        col_out_d    = col_out_q;
        prow_d       = prow_q;
        chan_d       = chan_q;
        frame_done_d = 1'b0;
        buf_we       = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        rd_addr      = CIW'(col_out_q >> 1);
        emit_bot     = (state_q == EMIT_BOT);

        unique case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (col_in_q == COL_IN_LAST) begin
                        col_in_d = '0;
                        state_d  = EMIT_TOP;
                    end else begin
                        col_in_d = col_in_q + CIW'(1);
                    end
                end
            end

            EMIT_TOP, EMIT_BOT: begin
                out_valid = 1'b1;
                // Output position inside the 2x2 window is {row, col_out[0]}.
                if (buf_idx_q[rd_addr] == {emit_bot, col_out_q[0]}) begin
                    out_data = buf_val_q[rd_addr];
                end
                out_last = emit_bot && (col_out_q == COL_OUT_LAST) && (prow_q == PROW_LAST);
                if (out_ready) begin
                    if (col_out_q != COL_OUT_LAST) begin
                        col_out_d = col_out_q + COW'(1);
                    end else begin
                        col_out_d = '0;
                        if (!emit_bot) begin
                            state_d = EMIT_BOT;
                        end else begin
                            state_d = FILL;
                            if (prow_q != PROW_LAST) begin
                                prow_d = prow_q + PRW'(1);
                            end else begin
                                prow_d = '0;
                                if (chan_q != CHAN_LAST) begin
                                    chan_d = chan_q + CHW'(1);
                                end else begin
                                    chan_d       = '0;
                                    frame_done_d = 1'b1;
                                end
                            end
                        end
                    end
                end
            end

            default: state_d = FILL;
        endcase
    end

endmodule

// File: doc/max_unpooling_stream.md
Name: max_unpooling_stream

Overview:
- Channel-serial 2x2 max-unpooling engine; the inverse of the 2x2 max-pooling stage.
- Accepts pooled feature-map elements, each with its 2-bit argmax position, and emits the 2H x 2W restored map in raster order.
- Every non-argmax location is zero.
- Sits on the decoder/upsampling side of the CNN datapath and streams channels 0..D-1 back-to-back.

Parameters:
- DATA_BITS, 32, element width.
- D, 32, channels per frame.
- H, 23, pooled map height (output height is 2H).
- W, 23, pooled map width (output width is 2W).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  pooled element valid.
- in_ready  output  1  block can accept a pooled element.
- in_data  input  DATA_BITS  pooled max value.
- in_idx  input  2  argmax position in the 2x2 window: bit1 = row (0 top, 1 bottom), bit0 = col (0 left, 1 right).
- out_valid  output  1  output element valid.
- out_ready  input  1  downstream accepts the output element.
- out_data  output  DATA_BITS  unpooled element.
- out_last  output  1  marks the final element of the current channel.
- frame_done  output  1  one-cycle pulse after the final element of channel D-1 is accepted.

Behaviour:
- Handshakes:
  - Input transfer happens when in_valid && in_ready at a rising clk edge.
  - Output transfer happens when out_valid && out_ready at a rising clk edge.
- Storage: one row buffer of W entries, each {DATA_BITS value, 2-bit idx}.
- Counters:
  - col_in: 0..W-1.
  - col_out: 0..2W-1.
  - prow: 0..H-1.
  - chan: 0..D-1.
- States:
  - FILL: in_ready=1, out_valid=0. Each accepted input is written to buf[col_in] and col_in increments. On acceptance with col_in==W-1: col_in<=0, go to EMIT_TOP.
  - EMIT_TOP: out_valid=1, in_ready=0. out_data = (buf[col_out>>1].idx == {1'b0, col_out[0]}) ? buf[col_out>>1].value : 0. On transfer col_out increments. Transfer at col_out==2W-1: col_out<=0, go to EMIT_BOT.
  - EMIT_BOT: same as EMIT_TOP, but the idx match is against {1'b1, col_out[0]}. Transfer at col_out==2W-1: col_out<=0, return to FILL, then:
    - If prow<H-1, prow increments.
    - Else prow<=0 and chan increments.
    - If chan was D-1, chan<=0 and frame_done pulses high for exactly the next cycle.
- out_last = 1 only in EMIT_BOT with col_out==2W-1 and prow==H-1.
- Stall: while out_valid && !out_ready, out_data, out_last and the state hold stable.
- in_valid is ignored in the EMIT states; nothing is captured or dropped silently, because upstream holds the element until in_ready.
- Latency: the first output is valid in the cycle after the W-th input of a row is accepted.
- Throughput per pooled row: W input cycles plus 4W output cycles at full out_ready.
- No arithmetic on data; values pass bit-exact. Zero fill is all DATA_BITS zero.
- W=1 and H=1 are legal; counters use ceil(log2) widths of their ranges, minimum 1 bit.
- Reset values:
  - state=FILL, all counters 0.
  - out_valid=0, out_data=0, out_last=0, frame_done=0.
  - in_ready is 1 after reset release.
  - Buffer contents are don't-care; they are always rewritten before being read.
- Reset mid-operation: all in-flight row, channel and frame progress is discarded immediately (async). The next accepted input is channel 0, pooled row 0, column 0.
- After frame_done the block continues seamlessly with the next frame at channel 0.

Test Plan:
- Reset: hold reset for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, frame_done=0. After release, in_ready=1 and the first accepted element lands in buf[0].
- Row expansion (DATA_BITS=8, W=2, H=2, D=2, out_ready=1): inputs {0x11, idx0}, {0x22, idx3} -> top row 11,00,00,00; bottom row 00,00,00,22. The first out_valid appears 1 cycle after the second input. in_ready is 0 for the 8 output cycles.
- Idx coverage: inputs {0xA1, idx1}, {0xB2, idx2} -> top row 00,A1,00,00; bottom row 00,00,B2,00.
- Backpressure: out_ready toggles 1,0,1,0 during emit -> each beat is held while out_ready=0. The sequence is identical to the unstalled case, with 16 beats per channel and no duplicates or drops.
- Full frame (D=2): 8 inputs -> 32 outputs. out_last is high on beats 16 and 32 only. frame_done pulses once, in the cycle after beat 32. The next input then starts channel 0 again.
- Reset mid-emit: assert reset after 3 output beats -> out_valid drops to 0 immediately and in_ready=1 after release. A fresh pooled row produces output from row 0 with no stale buffer data.
